// File: rtl/frame_acc.sv
`default_nettype none
// ============================================================================
//  Module   : frame_acc
//  Brief    : Accumulates FRAME_LEN unsigned MAC samples into one saturating
//             frame sum. The sum is presented with a valid/ready handshake,
//             and samples offered while not accepting are counted.
//  Revision : 1.0  initial release
// ============================================================================

// Shared widths of the MAC datapath.
package p;
  localparam int SIZE_DATA_OUT = 16;  // width of one MAC product-sum sample
  localparam int SIZE_REG      = 8;   // width of the MAC operand registers
endpackage

module frame_acc
  import p::*;
#(
  parameter int FRAME_LEN = 8,                  // samples per frame, 2..256
  parameter int ACC_W     = SIZE_DATA_OUT + 8   // accumulator width, >= SIZE_DATA_OUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [SIZE_DATA_OUT-1:0] in_data,
  input  logic                     start,
  input  logic                     out_ready,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     out_sat,
  output logic [7:0]               drop_cnt
);

  // One extra bit so that cnt can hold FRAME_LEN itself without wrapping.
  localparam int                CNT_W    = $clog2(FRAME_LEN) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam int                EXT_W    = ACC_W + 1 - SIZE_DATA_OUT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             accept;
  logic             drop;
  logic             clear;
  logic [ACC_W:0]   sum_wide;

  // Outputs depend on registered state only, so there is no combinational
  // path from in_valid or out_ready to any output.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign out_sum   = acc;
  assign out_sat   = sat;

  // A start while accumulating restarts the frame, so a sample offered in
  // that same cycle is discarded rather than folded into the new frame.
  assign accept = in_valid && (state == ACCUM) && !start;
  assign drop   = in_valid && ((state != ACCUM) || start);
  // Start is ignored in HOLD, so the held result survives until it is taken.
  assign clear  = start && (state != HOLD);

  // One bit wider than acc so that overflow is visible as the carry.
  assign sum_wide = {1'b0, acc} + {{EXT_W{1'b0}}, in_data};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept FRAME_LEN samples, then hold until consumed.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (accept && (cnt == CNT_LAST)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, sample counter and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (accept) begin
      if (sum_wide[ACC_W]) begin
        acc <= '1;
        sat <= 1'b1;
      end else begin
        acc <= sum_wide[ACC_W-1:0];
      end
      cnt <= cnt + 1'b1;
    end
  end

  // Lost-sample counter. It saturates at 255 and is cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'd0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_acc
//  Brief    : Directed, table-driven self-checking bench for frame_acc.
//             Instance a uses FRAME_LEN=4, ACC_W=18. Instance b uses
//             FRAME_LEN=4, ACC_W=17 and is the saturation case.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [17:0] out_sum_a;
  logic [7:0]  drop_cnt_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [16:0] out_sum_b;
  logic [7:0]  drop_cnt_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  frame_acc #(.FRAME_LEN(4), .ACC_W(18)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .start(start), .out_ready(out_ready), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_sum(out_sum_a), .out_sat(out_sat_a),
    .drop_cnt(drop_cnt_a)
  );

  frame_acc #(.FRAME_LEN(4), .ACC_W(17)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .start(start), .out_ready(out_ready), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_sum(out_sum_b), .out_sat(out_sat_b),
    .drop_cnt(drop_cnt_b)
  );

  typedef struct {
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [17:0] exp_sum;
    logic        exp_sat;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic iv, input logic [15:0] d,
                     input logic ordy, input logic e_rdy, input logic e_ov,
                     input logic [17:0] e_sum, input logic e_sat,
                     input logic [7:0] e_drop);
    vec_t v;
    v.start = st; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.exp_in_ready = e_rdy; v.exp_out_valid = e_ov; v.exp_sum = e_sum;
    v.exp_sat = e_sat; v.exp_drop = e_drop;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string tag, input logic rdy, input logic ov,
                       input logic [17:0] sum, input logic sat, input logic [7:0] drp);
    chk({tag, ".in_ready"},  {31'd0, in_ready_a},  {31'd0, rdy});
    chk({tag, ".out_valid"}, {31'd0, out_valid_a}, {31'd0, ov});
    chk({tag, ".out_sum"},   {14'd0, out_sum_a},   {14'd0, sum});
    chk({tag, ".out_sat"},   {31'd0, out_sat_a},   {31'd0, sat});
    chk({tag, ".drop_cnt"},  {24'd0, drop_cnt_a},  {24'd0, drp});
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic iv, input logic [15:0] d, input logic ordy);
    start = st; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // start, valid, data, ordy | in_ready, out_valid, sum, sat, drop (after edge)
    // Basic frame: 10+20+30+40 = 100, one-cycle HOLD with out_ready high.
    add(1, 0,  0, 0,  1, 0,   0, 0, 0);
    add(0, 1, 10, 0,  1, 0,  10, 0, 0);
    add(0, 1, 20, 0,  1, 0,  30, 0, 0);
    add(0, 1, 30, 0,  1, 0,  60, 0, 0);
    add(0, 1, 40, 1,  0, 1, 100, 0, 0);
    add(0, 0,  0, 1,  0, 0, 100, 0, 0);
    // Gapped input 1..4, then 5 cycles of backpressure (one with an ignored start).
    add(1, 0,  0, 0,  1, 0,   0, 0, 0);
    add(0, 1,  1, 0,  1, 0,   1, 0, 0);
    add(0, 0,  0, 0,  1, 0,   1, 0, 0);
    add(0, 1,  2, 0,  1, 0,   3, 0, 0);
    add(0, 0,  0, 0,  1, 0,   3, 0, 0);
    add(0, 1,  3, 0,  1, 0,   6, 0, 0);
    add(0, 0,  0, 0,  1, 0,   6, 0, 0);
    add(0, 1,  4, 0,  0, 1,  10, 0, 0);
    add(0, 0,  0, 0,  0, 1,  10, 0, 0);
    add(1, 0,  0, 0,  0, 1,  10, 0, 0);
    add(0, 0,  0, 0,  0, 1,  10, 0, 0);
    add(0, 0,  0, 0,  0, 1,  10, 0, 0);
    add(0, 0,  0, 0,  0, 1,  10, 0, 0);
    add(0, 0,  0, 1,  0, 0,  10, 0, 0);
    // Restart with a same-cycle sample (dropped), then 1+1+1+1 = 4.
    add(1, 0,  0, 0,  1, 0,   0, 0, 0);
    add(0, 1,  5, 0,  1, 0,   5, 0, 0);
    add(0, 1,  5, 0,  1, 0,  10, 0, 0);
    add(1, 1,  7, 0,  1, 0,   0, 0, 1);
    add(0, 1,  1, 0,  1, 0,   1, 0, 1);
    add(0, 1,  1, 0,  1, 0,   2, 0, 1);
    add(0, 1,  1, 0,  1, 0,   3, 0, 1);
    add(0, 1,  1, 0,  0, 1,   4, 0, 1);
    // Sample offered in HOLD is dropped; start with a sample in IDLE drops it too.
    add(0, 1,  9, 1,  0, 0,   4, 0, 2);
    add(1, 1,  9, 0,  1, 0,   0, 0, 3);

    // Asynchronous reset state, checked while still in reset.
    rst_n = 1'b0;
    #12;
    chk_a("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First start is honoured on the first edge after reset release.
    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      step();
      chk_a($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_out_valid,
            vecs[i].exp_sum, vecs[i].exp_sat, vecs[i].exp_drop);
    end

    // Saturation: four samples of 65535. The 17-bit instance clamps at 131071;
    // the 18-bit instance reaches 262140 without saturating.
    drive(1, 0, 0, 0); step();
    drive(0, 1, 16'hFFFF, 0); step();
    chk("sat.b.s1", {15'd0, out_sum_b}, 32'd65535);
    chk("sat.b.f1", {31'd0, out_sat_b}, 32'd0);
    step();
    chk("sat.b.s2", {15'd0, out_sum_b}, 32'd131070);
    chk("sat.b.f2", {31'd0, out_sat_b}, 32'd0);
    step();
    chk("sat.b.s3", {15'd0, out_sum_b}, 32'd131071);
    chk("sat.b.f3", {31'd0, out_sat_b}, 32'd1);
    step();
    chk("sat.b.valid", {31'd0, out_valid_b}, 32'd1);
    chk("sat.b.sum",   {15'd0, out_sum_b}, 32'd131071);
    chk("sat.b.flag",  {31'd0, out_sat_b}, 32'd1);
    chk_a("sat.a", 0, 1, 18'd262140, 0, 3);
    drive(0, 0, 0, 1); step();
    chk("sat.b.held", {31'd0, out_sat_b}, 32'd1);
    chk("sat.b.idle", {31'd0, out_valid_b}, 32'd0);
    drive(1, 0, 0, 0); step();
    chk("sat.b.clear", {31'd0, out_sat_b}, 32'd0);
    chk("sat.b.sum0",  {15'd0, out_sum_b}, 32'd0);
    drive(0, 0, 0, 0);

    // Drop counter saturation: reset, then 300 samples offered in IDLE.
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk_a("rst2", 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    drive(0, 1, 16'd3, 0);
    for (int i = 0; i < 300; i++) step();
    chk_a("dropsat", 0, 0, 0, 0, 8'd255);

    // Reset pulse mid-ACCUM: outputs go to 0 at once and the frame is lost.
    drive(1, 0, 0, 0); step();
    drive(0, 1, 16'd50, 0); step(); step();
    chk_a("preRst", 1, 0, 18'd100, 0, 8'd255);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("midRst", 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    drive(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk_a($sformatf("postRst%0d", i), 0, 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
